// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: collects M-stage exceptions and
// hardware interrupts, raises IntReq, holds EPC, and serves mfc0/mtc0 accesses.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID = 32'h0000_2020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  sr_im_reg;
    logic        sr_exl_reg;
    logic        sr_ie_reg;
    logic        cause_bd_reg;
    logic [5:0]  cause_ip_reg;
    logic [4:0]  cause_exc_reg;
    logic [31:0] epc_reg;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_pend = (|(HWInt & sr_im_reg)) & sr_ie_reg & ~sr_exl_reg;
    assign exc_pend = (ExcCode_M != 5'd0) & ~sr_exl_reg;
    assign IntReq   = int_pend | exc_pend;

    // A delay-slot instruction restarts at its branch so the branch re-executes.
    assign epc_next = (BD_M ? (PC_M - 32'd4) : PC_M) & ~32'h3;

    // Forwarding lets an eret directly behind an mtc0 EPC fetch the new address.
    assign EPC = (WE && (A2 == REG_EPC) && !IntReq) ? DIn : epc_reg;

    assign sr_word    = {16'h0, sr_im_reg, 8'h0, sr_exl_reg, sr_ie_reg};
    assign cause_word = {cause_bd_reg, 15'h0, cause_ip_reg, 3'h0, cause_exc_reg, 2'h0};

    always_comb begin
        DOut = 32'h0;
        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc_reg;
            REG_PRID:  DOut = PRID;
            default:   DOut = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_reg     <= 6'h0;
            sr_exl_reg    <= 1'b0;
            sr_ie_reg     <= 1'b0;
            cause_bd_reg  <= 1'b0;
            cause_ip_reg  <= 6'h0;
            cause_exc_reg <= 5'h0;
            epc_reg       <= 32'h0;
        end else begin
            cause_ip_reg <= HWInt;
            if (IntReq) begin
                sr_exl_reg    <= 1'b1;
                cause_exc_reg <= int_pend ? 5'd0 : ExcCode_M;
                cause_bd_reg  <= BD_M;
                epc_reg       <= epc_next;
            end else begin
                if (WE) begin
                    case (A2)
                        REG_SR: begin
                            sr_im_reg  <= DIn[15:10];
                            sr_exl_reg <= DIn[1];
                            sr_ie_reg  <= DIn[0];
                        end
                        REG_EPC: epc_reg <= DIn;
                        default: ;
                    endcase
                end
                // Later assignment wins: eret clears EXL after any same-cycle mtc0 SR.
                if (EXLClr) begin
                    sr_exl_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: table of vectors fed through a
// scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID_VAL   = 32'h0000_2020;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [4:0]  ExcCode_M;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        we;
        logic [31:0] din;
        logic        clr;
        logic [5:0]  hw;
        logic [4:0]  exc;
        logic [31:0] pc;
        logic        bd;
        logic        exp_int;
        logic [31:0] exp_epc;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    cp0_exc_ctrl #(.PRID(PRID_VAL)) dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .WE        (WE),
        .PC_M      (PC_M),
        .BD_M      (BD_M),
        .ExcCode_M (ExcCode_M),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .IntReq    (IntReq),
        .EPC       (EPC),
        .DOut      (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic [4:0] a1, logic [4:0] a2, logic we,
                                logic [31:0] din, logic clr, logic [5:0] hw, logic [4:0] exc,
                                logic [31:0] pc, logic bd, logic ei, logic [31:0] ee,
                                logic [31:0] ed);
        vec_t v;
        v.name = nm; v.a1 = a1; v.a2 = a2; v.we = we; v.din = din; v.clr = clr;
        v.hw = hw; v.exc = exc; v.pc = pc; v.bd = bd;
        v.exp_int = ei; v.exp_epc = ee; v.exp_dout = ed;
        return v;
    endfunction

    task automatic chk(string nm, string field, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %h required %h", nm, field, act, req);
        end else begin
            $display("ok   %s.%s = %h", nm, field, act);
        end
    endtask

    task automatic idle_inputs();
        A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; WE = 1'b0; PC_M = 32'h0;
        BD_M = 1'b0; ExcCode_M = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    endtask

    task automatic drive(vec_t v);
        A1 = v.a1; A2 = v.a2; WE = v.we; DIn = v.din; EXLClr = v.clr;
        HWInt = v.hw; ExcCode_M = v.exc; PC_M = v.pc; BD_M = v.bd;
        exp_q.push_back(v);
    endtask

    task automatic check_front();
        vec_t e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: got empty queue required one entry");
        end else begin
            e = exp_q.pop_front();
            chk(e.name, "IntReq", {31'h0, IntReq}, {31'h0, e.exp_int});
            chk(e.name, "EPC", EPC, e.exp_epc);
            chk(e.name, "DOut", DOut, e.exp_dout);
        end
    endtask

    initial begin
        //            name          a1  a2  we din            clr hw      exc    pc            bd  int epc            dout
        vecs.push_back(mk("rst_sr",     12, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0));
        vecs.push_back(mk("rst_prid",   15, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0000_2020));
        vecs.push_back(mk("adel",       13, 0,  0, 32'h0,        0, 6'h00, 5'd4,  32'h3001,     0, 1, 32'h0,        32'h0));
        vecs.push_back(mk("adel_cause", 13, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3000,     32'h10));
        vecs.push_back(mk("adel_sr",    12, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3000,     32'h2));
        vecs.push_back(mk("wr_cause",   13, 13, 1, 32'hFFFF_FFFF,0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3000,     32'h10));
        vecs.push_back(mk("cause_keep", 13, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3000,     32'h10));
        vecs.push_back(mk("rd_other",   7,  7,  1, 32'hFFFF_FFFF,0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3000,     32'h0));
        vecs.push_back(mk("masked",     14, 0,  0, 32'h0,        0, 6'h3F, 5'd10, 32'h5000,     0, 0, 32'h3000,     32'h3000));
        vecs.push_back(mk("cause_ip",   13, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3000,     32'hFC10));
        vecs.push_back(mk("sr_wr_clr",  12, 12, 1, 32'h403,      1, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3000,     32'h2));
        vecs.push_back(mk("sr_after",   12, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3000,     32'h401));
        vecs.push_back(mk("epc_fwd",    14, 14, 1, 32'h3100,     0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3100,     32'h3000));
        vecs.push_back(mk("epc_reg",    14, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3100,     32'h3100));
        vecs.push_back(mk("ds_int",     13, 0,  0, 32'h0,        0, 6'h01, 5'd4,  32'h3024,     1, 1, 32'h3100,     32'h10));
        vecs.push_back(mk("ds_cause",   13, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3020,     32'h8000_0400));
        vecs.push_back(mk("ds_sr",      12, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3020,     32'h403));
        vecs.push_back(mk("mask2",      14, 0,  0, 32'h0,        0, 6'h3F, 5'd10, 32'h6000,     0, 0, 32'h3020,     32'h3020));
        vecs.push_back(mk("eret",       12, 0,  0, 32'h0,        1, 6'h3F, 5'd0,  32'h0,        0, 0, 32'h3020,     32'h403));
        vecs.push_back(mk("unmasked",   12, 0,  0, 32'h0,        0, 6'h3F, 5'd0,  32'h6004,     0, 1, 32'h3020,     32'h401));
        vecs.push_back(mk("eret2",      14, 0,  0, 32'h0,        1, 6'h00, 5'd0,  32'h0,        0, 0, 32'h6004,     32'h6004));
        vecs.push_back(mk("wr_dropped", 14, 14, 1, 32'h3100,     0, 6'h00, 5'd4,  32'h7008,     0, 1, 32'h6004,     32'h6004));
        vecs.push_back(mk("epc_pc",     14, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h7008,     32'h7008));
        vecs.push_back(mk("eret3",      13, 0,  0, 32'h0,        1, 6'h00, 5'd0,  32'h0,        0, 0, 32'h7008,     32'h10));
        vecs.push_back(mk("wrap_exc",   0,  0,  0, 32'h0,        0, 6'h00, 5'd5,  32'h2,        1, 1, 32'h7008,     32'h0));
        vecs.push_back(mk("wrap_epc",   14, 0,  0, 32'h0,        0, 6'h00, 5'd0,  32'h0,        0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk("wr_epc_x",   14, 14, 1, 32'h3010,     0, 6'h00, 5'd0,  32'h0,        0, 0, 32'h3010,     32'hFFFF_FFFC));
        vecs.push_back(mk("pre_rst",    12, 0,  0, 32'h0,        0, 6'h3F, 5'd0,  32'h0,        0, 0, 32'h3010,     32'h403));

        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_front();
        end

        // Asynchronous reset mid-phase, with EXL=1 and EPC=0x3010 held.
        @(negedge clk);
        idle_inputs();
        A1 = 5'd12;
        HWInt = 6'h3F;
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst", "IntReq", {31'h0, IntReq}, 32'h0);
        chk("async_rst", "EPC", EPC, 32'h0);
        chk("async_rst", "DOut_sr", DOut, 32'h0);
        A1 = 5'd13;
        #1;
        chk("async_rst", "DOut_cause", DOut, 32'h0);
        A1 = 5'd15;
        #1;
        chk("async_rst", "DOut_prid", DOut, PRID_VAL);
        @(negedge clk);
        reset = 1'b1;
        A1 = 5'd12;
        @(negedge clk);
        #1;
        chk("post_rst", "DOut_sr", DOut, 32'h0);
        chk("post_rst", "IntReq", {31'h0, IntReq}, 32'h0);

        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", exp_q.size());
        end

        $display("handler pc reference %h", HANDLER_PC);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
